edge_count_reader: RTL

Downstream consumer of the three edge-counter results (d1_count, d2_count, d3_count). On a read request it snapshots all three 32-bit counts atomically and streams them as a fixed 14-byte frame over a byte-wide valid/ready interface toward the host transmitter (UART TX path). The frame carries a header byte and an XOR checksum. One reader instance serves one edge counter instance.

---
 rtl/trigger_pkg.sv | 23 ++
 rtl/edge_count_reader.sv | 127 ++++++++++++
 2 files changed

// File: rtl/trigger_pkg.sv
// Shared types and frame layout constants for the edge-count frame reader.
package trigger_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int         FRAME_LEN    = 14;
  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

  // Byte positions within the frame; each count occupies four bytes, MSB first.
  localparam logic [3:0] D1_IDX  = 4'd1;
  localparam logic [3:0] D2_IDX  = 4'd5;
  localparam logic [3:0] D3_IDX  = 4'd9;
  localparam logic [3:0] CHK_IDX = 4'd13;

  // XOR of the four bytes of one 32-bit count.
  function automatic logic [7:0] word_xor(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

endpackage

// File: rtl/edge_count_reader.sv
// Snapshots three edge-counter results on request and streams them as a
// 14-byte frame (header, d1, d2, d3 big-endian, XOR checksum) over a
// byte-wide valid/ready link.
//
// state | meaning
// IDLE  | waiting for rd_req; tx_valid low
// SEND  | presenting frame byte idx_q; advances on tx_valid && tx_ready
module edge_count_reader
  import trigger_pkg::*;
#(
  parameter int         COUNT_W  = 32,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_req,
  input  logic [COUNT_W-1:0] d1_count,
  input  logic [COUNT_W-1:0] d2_count,
  input  logic [COUNT_W-1:0] d3_count,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               done,
  output logic               req_drop
);

  state_t             state_q, state_d;
  logic [3:0]         idx_q;
  logic [3:0]         idx_nxt;
  logic [COUNT_W-1:0] snap_d1_q, snap_d2_q, snap_d3_q;
  logic [7:0]         chk_q;
  logic [7:0]         tx_data_q;
  logic [7:0]         nxt_byte;
  logic               done_q;
  logic               drop_q;

  logic accept;
  logic xfer;
  logic last_xfer;

  assign accept    = (state_q == IDLE) && rd_req;
  assign xfer      = (state_q == SEND) && tx_ready;
  assign last_xfer = xfer && (idx_q == CHK_IDX);
  assign idx_nxt   = idx_q + 4'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_req)    state_d = SEND;
      SEND:    if (last_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame byte for the index that follows the one currently on the link.
  always_comb begin
    nxt_byte = 8'h00;
    case (idx_nxt)
      4'd1:    nxt_byte = snap_d1_q[31:24];
      4'd2:    nxt_byte = snap_d1_q[23:16];
      4'd3:    nxt_byte = snap_d1_q[15:8];
      4'd4:    nxt_byte = snap_d1_q[7:0];
      4'd5:    nxt_byte = snap_d2_q[31:24];
      4'd6:    nxt_byte = snap_d2_q[23:16];
      4'd7:    nxt_byte = snap_d2_q[15:8];
      4'd8:    nxt_byte = snap_d2_q[7:0];
      4'd9:    nxt_byte = snap_d3_q[31:24];
      4'd10:   nxt_byte = snap_d3_q[23:16];
      4'd11:   nxt_byte = snap_d3_q[15:8];
      4'd12:   nxt_byte = snap_d3_q[7:0];
      4'd13:   nxt_byte = chk_q;
      default: nxt_byte = 8'h00;
    endcase
  end

  // Snapshot, byte index, registered tx_data and the single-cycle pulses.
  // tx_data only moves on a handshake, so it holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= 4'd0;
      snap_d1_q <= '0;
      snap_d2_q <= '0;
      snap_d3_q <= '0;
      chk_q     <= 8'h00;
      tx_data_q <= 8'h00;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      done_q <= last_xfer;
      drop_q <= rd_req && (state_q == SEND);
      if (accept) begin
        snap_d1_q <= d1_count;
        snap_d2_q <= d2_count;
        snap_d3_q <= d3_count;
        chk_q     <= word_xor(d1_count) ^ word_xor(d2_count) ^ word_xor(d3_count);
        idx_q     <= 4'd0;
        tx_data_q <= HDR_BYTE;
      end else if (xfer) begin
        if (idx_q == CHK_IDX) begin
          idx_q     <= 4'd0;
          tx_data_q <= 8'h00;
        end else begin
          idx_q     <= idx_nxt;
          tx_data_q <= nxt_byte;
        end
      end
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    tx_valid = (state_q == SEND);
    busy     = (state_q == SEND);
    tx_data  = tx_data_q;
    done     = done_q;
    req_drop = drop_q;
  end

endmodule
